// File: rtl/inst_step_ctrl_pkg.sv
// Shared types and constants for the instruction step controller and its ROM.
package inst_step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int PC_STEP       = 4;
    localparam int PC_ALIGN_BITS = 2;

    // Defaults also used when sizing the instruction ROM.
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_LAST_WORD = 63;

endpackage

// File: rtl/inst_step_ctrl_if.sv
// ROM read port between the step controller (master) and the instruction ROM (slave).
interface inst_step_ctrl_if
    import inst_step_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic [ADDR_W-1:0] ROM_ADDR;
    logic [31:0]       ROM_DOUT;

    modport master (output ROM_ADDR, input ROM_DOUT);
    modport slave  (input ROM_ADDR, output ROM_DOUT);

endinterface

// File: rtl/inst_step_ctrl_debounce.sv
// Button debouncer: 3-stage sampler, emits one pulse on a debounced press (falling edge).
module btn_debounce (
    input  logic BJ_CLK,
    input  logic RESET,
    input  logic button,
    output logic press
);

    logic [2:0] stg;
    logic       deb;
    logic       deb_q;

    // Two consecutive low samples are needed before the debounced level drops.
    assign deb   = stg[1] | stg[2];
    assign press = deb_q & ~deb;

    always_ff @(posedge BJ_CLK or negedge RESET) begin
        if (!RESET) begin
            stg   <= '1;
            deb_q <= 1'b1;
        end else begin
            stg   <= {stg[1:0], button};
            deb_q <= deb;
        end
    end

endmodule

// File: rtl/inst_step_ctrl.sv
// Instruction step controller: owns the PC, steps on button or auto-run tick,
// waits out the ROM latency, captures the word and drives the selected LED byte.
module inst_step_ctrl
    import inst_step_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ROM_LAT   = 1,
    parameter int LAST_WORD = DEF_LAST_WORD,
    parameter int RUN_DIV   = 20
) (
    input  logic                  BJ_CLK,
    input  logic                  RESET,
    input  logic                  BUTTON_IN,
    input  logic                  RUN,
    input  logic [1:0]            SELECT,
    inst_step_ctrl_if.master      rom,
    output logic [31:0]           PC,
    output logic [31:0]           INST,
    output logic [7:0]            LED,
    output logic                  BUSY,
    output logic                  WRAP
);

    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int DIV_W = $clog2(RUN_DIV);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DIV_W-1:0]   div;
    logic               pending;
    logic               press;
    logic               run_tick;
    logic               step_req;
    logic               at_last;
    logic [31:0]        pc_next;

    btn_debounce u_deb (
        .BJ_CLK (BJ_CLK),
        .RESET  (RESET),
        .button (BUTTON_IN),
        .press  (press)
    );

    assign rom.ROM_ADDR = PC[ADDR_W+PC_ALIGN_BITS-1:PC_ALIGN_BITS];
    assign BUSY         = (state != IDLE);

    assign run_tick = RUN && (div == DIV_W'(RUN_DIV - 1));
    assign step_req = press | run_tick;
    assign at_last  = (PC[ADDR_W+PC_ALIGN_BITS-1:PC_ALIGN_BITS] == ADDR_W'(LAST_WORD));
    assign pc_next  = at_last ? 32'd0 : PC + 32'(PC_STEP);

    always_ff @(posedge BJ_CLK or negedge RESET) begin
        if (!RESET) begin
            div <= '0;
        end else if (!RUN || run_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Reset lands in WAIT so word 0 is fetched without any step request.
    always_ff @(posedge BJ_CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= WAIT;
            cnt     <= '0;
            PC      <= '0;
            INST    <= '0;
            WRAP    <= 1'b0;
            pending <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            // Only presses queue while busy; run ticks are simply lost.
            if (state != IDLE && press)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (step_req || pending) begin
                        PC      <= pc_next;
                        WRAP    <= at_last;
                        state   <= WAIT;
                        cnt     <= '0;
                        pending <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ROM_LAT - 1))
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    INST  <= rom.ROM_DOUT;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge BJ_CLK or negedge RESET) begin
        if (!RESET) begin
            LED <= '0;
        end else begin
            case (SELECT)
                2'd0:    LED <= INST[7:0];
                2'd1:    LED <= INST[15:8];
                2'd2:    LED <= INST[23:16];
                default: LED <= INST[31:24];
            endcase
        end
    end

endmodule
